// File: rtl/pkt_queue_head_updater.sv
// Commits software head-pointer writes, notifies the queue manager, and requests an extra
// descriptor (deduplicated per queue) whenever the queue still holds packets past the new head.
module pkt_queue_head_updater #(
  parameter int NB_QUEUES       = 512,
  parameter int PTR_WIDTH       = 32,
  parameter int BRAM_RD_LATENCY = 2,
  parameter int REQ_FIFO_DEPTH  = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wr_valid,
  output logic                         wr_ready,
  input  logic [$clog2(NB_QUEUES)-1:0] wr_queue_idx,
  input  logic [PTR_WIDTH-1:0]         wr_head,
  output logic                         head_wr_en,
  output logic [$clog2(NB_QUEUES)-1:0] head_wr_addr,
  output logic [PTR_WIDTH-1:0]         head_wr_data,
  output logic                         tail_rd_en,
  output logic [$clog2(NB_QUEUES)-1:0] tail_rd_addr,
  input  logic [PTR_WIDTH-1:0]         tail_rd_data,
  input  logic                         tail_wr_en,
  input  logic [$clog2(NB_QUEUES)-1:0] tail_wr_addr,
  input  logic [PTR_WIDTH-1:0]         tail_wr_data,
  output logic                         queue_updated,
  output logic [$clog2(NB_QUEUES)-1:0] updated_queue_idx,
  output logic                         dsc_req_valid,
  input  logic                         dsc_req_ready,
  output logic [$clog2(NB_QUEUES)-1:0] dsc_req_queue_idx
);

  localparam int IDX_W = $clog2(NB_QUEUES);
  localparam int LAT   = BRAM_RD_LATENCY;
  localparam int AW    = $clog2(REQ_FIFO_DEPTH);
  localparam int CNT_W = AW + 1;
  localparam int SUM_W = CNT_W + 3;

  logic                          ready_en_reg;
  logic                          accept;

  logic [LAT:1]                  stg_valid_reg;
  logic [LAT:1][IDX_W-1:0]       stg_idx_reg;
  logic [LAT:1][PTR_WIDTH-1:0]   stg_head_reg;
  logic [LAT:1]                  stg_ovr_reg;
  logic [LAT:1][PTR_WIDTH-1:0]   stg_tail_reg;
  logic [LAT:1]                  stg_snoop;

  logic                          queue_updated_reg;
  logic [IDX_W-1:0]              updated_idx_reg;

  logic [IDX_W-1:0]              fifo_mem [REQ_FIFO_DEPTH];
  logic [AW-1:0]                 wr_ptr_reg;
  logic [AW-1:0]                 rd_ptr_reg;
  logic [CNT_W-1:0]              fifo_count_reg;
  logic [NB_QUEUES-1:0]          pending_reg;

  logic [SUM_W-1:0]              inflight;
  logic                          cmp_snoop;
  logic [PTR_WIDTH-1:0]          eff_tail;
  logic [IDX_W-1:0]              cmp_idx;
  logic                          mismatch;
  logic                          push;
  logic                          pop;
  logic [IDX_W-1:0]              pop_idx;

  // Reserve FIFO space for every compare still in the pipe so no result can be lost.
  always_comb begin
    inflight = '0;
    for (int k = 1; k <= LAT; k++) begin
      inflight = inflight + SUM_W'(stg_valid_reg[k]);
    end
  end

  assign wr_ready = ready_en_reg &&
                    ((SUM_W'(fifo_count_reg) + inflight) < SUM_W'(REQ_FIFO_DEPTH));
  assign accept   = wr_valid && wr_ready;

  assign head_wr_en   = accept;
  assign head_wr_addr = wr_queue_idx;
  assign head_wr_data = wr_head;
  assign tail_rd_en   = accept;
  assign tail_rd_addr = wr_queue_idx;

  // Snoop hit for the value entering each stage; stage 1 captures the accept-cycle snoop.
  always_comb begin
    stg_snoop    = '0;
    stg_snoop[1] = tail_wr_en && (tail_wr_addr == wr_queue_idx);
    for (int k = 2; k <= LAT; k++) begin
      stg_snoop[k] = tail_wr_en && (tail_wr_addr == stg_idx_reg[k-1]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en_reg  <= 1'b0;
      stg_valid_reg <= '0;
      stg_idx_reg   <= '0;
      stg_head_reg  <= '0;
      stg_ovr_reg   <= '0;
      stg_tail_reg  <= '0;
    end else begin
      ready_en_reg     <= 1'b1;
      stg_valid_reg[1] <= accept;
      stg_idx_reg[1]   <= wr_queue_idx;
      stg_head_reg[1]  <= wr_head;
      stg_ovr_reg[1]   <= stg_snoop[1];
      stg_tail_reg[1]  <= tail_wr_data;
      for (int k = 2; k <= LAT; k++) begin
        stg_valid_reg[k] <= stg_valid_reg[k-1];
        stg_idx_reg[k]   <= stg_idx_reg[k-1];
        stg_head_reg[k]  <= stg_head_reg[k-1];
        stg_ovr_reg[k]   <= stg_ovr_reg[k-1] || stg_snoop[k];
        stg_tail_reg[k]  <= stg_snoop[k] ? tail_wr_data : stg_tail_reg[k-1];
      end
    end
  end

  // Newest tail wins: same-cycle snoop, then any captured snoop, then the BRAM read.
  assign cmp_idx   = stg_idx_reg[LAT];
  assign cmp_snoop = tail_wr_en && (tail_wr_addr == cmp_idx);
  assign eff_tail  = cmp_snoop ? tail_wr_data :
                     (stg_ovr_reg[LAT] ? stg_tail_reg[LAT] : tail_rd_data);
  assign mismatch  = stg_valid_reg[LAT] && (eff_tail != stg_head_reg[LAT]);

  assign dsc_req_valid     = (fifo_count_reg != '0);
  assign pop_idx           = fifo_mem[rd_ptr_reg];
  assign dsc_req_queue_idx = pop_idx;
  assign pop               = dsc_req_valid && dsc_req_ready;
  assign push              = mismatch &&
                             (!pending_reg[cmp_idx] || (pop && (pop_idx == cmp_idx)));

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= cmp_idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg        <= '0;
      rd_ptr_reg        <= '0;
      fifo_count_reg    <= '0;
      pending_reg       <= '0;
      queue_updated_reg <= 1'b0;
      updated_idx_reg   <= '0;
    end else begin
      queue_updated_reg <= accept;
      updated_idx_reg   <= wr_queue_idx;
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      fifo_count_reg <= fifo_count_reg + CNT_W'(push) - CNT_W'(pop);
      if (pop) begin
        pending_reg[pop_idx] <= 1'b0;
      end
      if (push) begin
        pending_reg[cmp_idx] <= 1'b1;
      end
    end
  end

  assign queue_updated     = queue_updated_reg;
  assign updated_queue_idx = updated_idx_reg;

endmodule

// File: tb/tb_pkt_queue_head_updater.sv
// Directed bench for pkt_queue_head_updater with a 2-cycle tail BRAM model.
module tb_pkt_queue_head_updater;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_valid;
  logic        wr_ready;
  logic [8:0]  wr_queue_idx;
  logic [31:0] wr_head;
  logic        head_wr_en;
  logic [8:0]  head_wr_addr;
  logic [31:0] head_wr_data;
  logic        tail_rd_en;
  logic [8:0]  tail_rd_addr;
  logic [31:0] tail_rd_data;
  logic        tail_wr_en;
  logic [8:0]  tail_wr_addr;
  logic [31:0] tail_wr_data;
  logic        queue_updated;
  logic [8:0]  updated_queue_idx;
  logic        dsc_req_valid;
  logic        dsc_req_ready;
  logic [8:0]  dsc_req_queue_idx;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pkt_queue_head_updater #(
    .NB_QUEUES(512), .PTR_WIDTH(32), .BRAM_RD_LATENCY(2), .REQ_FIFO_DEPTH(16)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_queue_idx(wr_queue_idx), .wr_head(wr_head),
    .head_wr_en(head_wr_en), .head_wr_addr(head_wr_addr), .head_wr_data(head_wr_data),
    .tail_rd_en(tail_rd_en), .tail_rd_addr(tail_rd_addr), .tail_rd_data(tail_rd_data),
    .tail_wr_en(tail_wr_en), .tail_wr_addr(tail_wr_addr), .tail_wr_data(tail_wr_data),
    .queue_updated(queue_updated), .updated_queue_idx(updated_queue_idx),
    .dsc_req_valid(dsc_req_valid), .dsc_req_ready(dsc_req_ready),
    .dsc_req_queue_idx(dsc_req_queue_idx)
  );

  // Tails BRAM: writes come only through the snoop port, reads return two cycles later.
  logic [31:0] tails [512];
  logic [31:0] rd_p1;
  logic [31:0] rd_p2;
  always @(posedge clk) begin
    if (tail_wr_en) tails[tail_wr_addr] <= tail_wr_data;
    if (tail_rd_en) rd_p1 <= tails[tail_rd_addr];
    rd_p2 <= rd_p1;
  end
  assign tail_rd_data = rd_p2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %-14s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_tail(input int q, input logic [31:0] v);
    tail_wr_en   = 1'b1;
    tail_wr_addr = 9'(q);
    tail_wr_data = v;
    tick();
    tail_wr_en   = 1'b0;
  endtask

  task automatic pop_one;
    dsc_req_ready = 1'b1;
    tick();
    dsc_req_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; wr_valid = 1'b0; wr_queue_idx = '0; wr_head = '0;
    tail_wr_en = 1'b0; tail_wr_addr = '0; tail_wr_data = '0; dsc_req_ready = 1'b0;
    tick(); tick();
    chk("rst_ready", 32'(wr_ready), 32'd0);
    chk("rst_dsc", 32'(dsc_req_valid), 32'd0);
    chk("rst_upd", 32'(queue_updated), 32'd0);
    rst_n = 1'b1;
    #1 chk("rel_ready", 32'(wr_ready), 32'd0);
    tick();
    chk("ready_up", 32'(wr_ready), 32'd1);

    // Head equals tail: commit and pulse only.
    set_tail(5, 32'h40);
    wr_valid = 1'b1; wr_queue_idx = 9'd5; wr_head = 32'h40;
    #1;
    chk("t1_hwen", 32'(head_wr_en), 32'd1);
    chk("t1_hwaddr", 32'(head_wr_addr), 32'd5);
    chk("t1_hwdata", head_wr_data, 32'h40);
    chk("t1_rden", 32'(tail_rd_en), 32'd1);
    chk("t1_rdaddr", 32'(tail_rd_addr), 32'd5);
    chk("t1_upd_T", 32'(queue_updated), 32'd0);
    tick(); wr_valid = 1'b0;
    #1;
    chk("t1_upd", 32'(queue_updated), 32'd1);
    chk("t1_updidx", 32'(updated_queue_idx), 32'd5);
    tick();
    chk("t1_upd_off", 32'(queue_updated), 32'd0);
    tick();
    chk("t1_nodsc", 32'(dsc_req_valid), 32'd0);

    // Residue packets: request raised at T+3.
    set_tail(7, 32'h100);
    wr_valid = 1'b1; wr_queue_idx = 9'd7; wr_head = 32'h80;
    tick(); wr_valid = 1'b0;
    tick();
    chk("t2_early", 32'(dsc_req_valid), 32'd0);
    tick();
    chk("t2_valid", 32'(dsc_req_valid), 32'd1);
    chk("t2_idx", 32'(dsc_req_queue_idx), 32'd7);
    pop_one();
    chk("t2_popped", 32'(dsc_req_valid), 32'd0);

    // Two writes to queue 3 back-to-back: two pulses, one request.
    set_tail(3, 32'h60);
    wr_valid = 1'b1; wr_queue_idx = 9'd3; wr_head = 32'h20;
    tick();
    chk("t3_upd1", 32'(queue_updated), 32'd1);
    chk("t3_rdy", 32'(wr_ready), 32'd1);
    tick(); wr_valid = 1'b0;
    chk("t3_upd2", 32'(queue_updated), 32'd1);
    chk("t3_upd2idx", 32'(updated_queue_idx), 32'd3);
    tick();
    chk("t3_upd_off", 32'(queue_updated), 32'd0);
    chk("t3_valid", 32'(dsc_req_valid), 32'd1);
    chk("t3_idx", 32'(dsc_req_queue_idx), 32'd3);
    tick();
    chk("t3_hold", 32'(dsc_req_valid), 32'd1);
    pop_one();
    chk("t3_dedup", 32'(dsc_req_valid), 32'd0);
    wr_valid = 1'b1;
    tick(); wr_valid = 1'b0;
    tick(); tick();
    chk("t3_again", 32'(dsc_req_valid), 32'd1);
    chk("t3_againidx", 32'(dsc_req_queue_idx), 32'd3);
    pop_one();

    // Snoop at T+1 makes the stale BRAM read irrelevant.
    set_tail(9, 32'h10);
    wr_valid = 1'b1; wr_queue_idx = 9'd9; wr_head = 32'h20;
    tick(); wr_valid = 1'b0;
    tail_wr_en = 1'b1; tail_wr_addr = 9'd9; tail_wr_data = 32'h20;
    tick(); tail_wr_en = 1'b0;
    tick(); tick();
    chk("t4_bypass", 32'(dsc_req_valid), 32'd0);

    // Fill the request FIFO: 16 accepts, then back-pressure, then in-order drain.
    for (int i = 0; i < 16; i++) set_tail(20 + i, 32'h1);
    for (int i = 0; i < 16; i++) begin
      wr_valid = 1'b1; wr_queue_idx = 9'(20 + i); wr_head = 32'h2;
      #1 chk("t5_fill_rdy", 32'(wr_ready), 32'd1);
      tick();
    end
    wr_valid = 1'b0;
    #1 chk("t5_full_rdy", 32'(wr_ready), 32'd0);
    tick(); tick(); tick();
    chk("t5_still_full", 32'(wr_ready), 32'd0);
    for (int i = 0; i < 16; i++) begin
      chk("t5_drain_v", 32'(dsc_req_valid), 32'd1);
      chk("t5_drain_idx", 32'(dsc_req_queue_idx), 32'(20 + i));
      pop_one();
    end
    chk("t5_empty", 32'(dsc_req_valid), 32'd0);
    chk("t5_rdy_back", 32'(wr_ready), 32'd1);

    // Reset with three queued requests and one compare in flight.
    for (int i = 0; i < 4; i++) set_tail(40 + i, 32'h1);
    for (int i = 0; i < 4; i++) begin
      wr_valid = 1'b1; wr_queue_idx = 9'(40 + i); wr_head = 32'h2;
      tick();
    end
    wr_valid = 1'b0;
    tick();
    chk("t6_queued", 32'(dsc_req_valid), 32'd1);
    chk("t6_qidx", 32'(dsc_req_queue_idx), 32'd40);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_dsc", 32'(dsc_req_valid), 32'd0);
    chk("t6_rst_rdy", 32'(wr_ready), 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("t6_rdy", 32'(wr_ready), 32'd1);
    chk("t6_flushed", 32'(dsc_req_valid), 32'd0);
    wr_valid = 1'b1; wr_queue_idx = 9'd40; wr_head = 32'h2;
    tick(); wr_valid = 1'b0;
    tick(); tick();
    chk("t6_rereq", 32'(dsc_req_valid), 32'd1);
    chk("t6_reidx", 32'(dsc_req_queue_idx), 32'd40);
    pop_one();
    tick();
    chk("t6_single", 32'(dsc_req_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pkt_queue_head_updater.md
Name: pkt_queue_head_updater

Overview:
Software-facing end of the packet-queue pointer protocol. Accepts decoded head-pointer writes from the PCIe MMIO path, commits each head to the queue heads BRAM, and pulses queue_updated/updated_queue_idx toward the packet queue manager. It also reads the queue's current tail; if tail != new head, residue packets exist, so it enqueues a deduplicated descriptor request for fpga2cpu.

Parameters:
NB_QUEUES, 512, number of packet queues; power of two, >= 2.
PTR_WIDTH, 32, head/tail pointer width.
BRAM_RD_LATENCY, 2, tail BRAM read latency in cycles (1..4).
REQ_FIFO_DEPTH, 16, descriptor-request FIFO depth; power of two.

Ports:
clk  in  1  clock.
rst_n  in  1  asynchronous active-low reset.
wr_valid  in  1  head write valid.
wr_ready  out  1  head write ready.
wr_queue_idx  in  $clog2(NB_QUEUES)  target queue.
wr_head  in  PTR_WIDTH  new head pointer.
head_wr_en  out  1  heads BRAM write enable.
head_wr_addr  out  $clog2(NB_QUEUES)  heads BRAM address.
head_wr_data  out  PTR_WIDTH  heads BRAM data.
tail_rd_en  out  1  tails BRAM read enable.
tail_rd_addr  out  $clog2(NB_QUEUES)  tails BRAM read address.
tail_rd_data  in  PTR_WIDTH  tails BRAM read data, valid BRAM_RD_LATENCY cycles after tail_rd_en.
tail_wr_en  in  1  snoop: tails BRAM write from queue manager.
tail_wr_addr  in  $clog2(NB_QUEUES)  snoop address.
tail_wr_data  in  PTR_WIDTH  snoop data.
queue_updated  out  1  one-cycle pulse per committed head write.
updated_queue_idx  out  $clog2(NB_QUEUES)  queue of that pulse.
dsc_req_valid  out  1  descriptor request valid.
dsc_req_ready  in  1  descriptor request ready.
dsc_req_queue_idx  out  $clog2(NB_QUEUES)  queue needing an extra descriptor.

Behaviour:
- Reset (rst_n low, async): all valids/enables/pulses 0, FIFO empty, pending bitmap cleared, pipeline flushed; wr_ready 0 during reset, 1 from first clk edge after deassertion. Reset mid-operation discards in-flight writes and queued requests.
- Accept on wr_valid & wr_ready (cycle T): head_wr_en/addr/data and tail_rd_en/addr driven combinationally in T (BRAM sees the write at edge ending T). queue_updated=1 and updated_queue_idx registered in T+1. Back-to-back accepts allowed every cycle.
- wr_ready = (fifo_count + inflight) < REQ_FIFO_DEPTH, where inflight = valid pipeline stages awaiting compare. This guarantees no compare result is ever dropped for lack of space.
- Compare stage at T+BRAM_RD_LATENCY: effective tail = tail_rd_data, overridden by the newest tail_wr_data to the same queue snooped in cycles T..T+BRAM_RD_LATENCY, inclusive. The same-cycle snoop at compare wins. Full PTR_WIDTH equality compare, no wrap arithmetic.
- tail != head and pending[idx]==0: push idx, set pending[idx]. tail != head with pending set: drop (dedup). tail == head: no push.
- Output: FIFO head drives dsc_req_*; pop on dsc_req_valid & dsc_req_ready, clearing pending[idx] in the same cycle. If pop and push target the same idx in the same cycle, the push wins and pending stays 1.
- Two writes to the same queue in flight: each commits in order and each pulses queue_updated. Each compares against its own head.
- FIFO full: wr_ready low and no acceptance. Empty: dsc_req_valid=0.

Test Plan:
- Reset, then write q=5 head=0x40 with tail[5]=0x40 -> head_wr 5/0x40 in T, queue_updated pulse idx 5 in T+1, no dsc_req.
- tail[7]=0x100, write q=7 head=0x80 -> dsc_req_valid with idx 7 at T+BRAM_RD_LATENCY+1.
- Write q=3 head=0x20 twice back-to-back, tail[3]=0x60, dsc_req_ready=0 -> two queue_updated pulses, exactly one dsc_req (idx 3). After pop, a third write -> new request.
- tail[9]=0x10, write q=9 head=0x20, snoop tail_wr 9/0x20 at T+1 -> no dsc_req (snoop bypass).
- dsc_req_ready=0, 16 writes to distinct queues all with tail!=head -> wr_ready drops once count+inflight=16, no loss, 16 requests drain in order.
- Assert rst_n low with 3 requests queued and 1 in flight -> dsc_req_valid=0 immediately; after release, the same queue can raise a request again.
